// File: rtl/reindeer_pipeline_sequencer_if.sv
// Handshake bundle between the Reindeer pipeline sequencer and the blocks it
// controls: debug start/halt, decoder control flags, memory and mul/div
// completion, interrupt status, and the sequencer's stage strobes.
//
// Modports:
//   slave  - the sequencer: samples requests/flags, drives strobes and status
//   master - the surrounding core / bench: drives requests, observes strobes
interface reindeer_pipeline_sequencer_if;
    // toward the sequencer
    logic       start;
    logic       halt_req;
    logic       fetch_done;
    logic       ctl_LOAD;
    logic       ctl_STORE;
    logic       ctl_MUL_DIV_FUNCT3;
    logic       ctl_WFI;
    logic       ctl_MRET;
    logic       exception_in;
    logic       mem_ack;
    logic       mem_error;
    logic       mul_div_done;
    logic       interrupt_pending;
    logic       global_int_enable;
    // from the sequencer
    logic       fetch_enable;
    logic       decode_enable;
    logic       exe_enable;
    logic       mem_enable;
    logic       wb_enable;
    logic       trap_enter;
    logic [3:0] trap_cause;
    logic       retire;
    logic       halted;

    modport slave (
        input  start, halt_req, fetch_done,
        input  ctl_LOAD, ctl_STORE, ctl_MUL_DIV_FUNCT3, ctl_WFI, ctl_MRET,
        input  exception_in, mem_ack, mem_error, mul_div_done,
        input  interrupt_pending, global_int_enable,
        output fetch_enable, decode_enable, exe_enable, mem_enable, wb_enable,
        output trap_enter, trap_cause, retire, halted
    );

    modport master (
        output start, halt_req, fetch_done,
        output ctl_LOAD, ctl_STORE, ctl_MUL_DIV_FUNCT3, ctl_WFI, ctl_MRET,
        output exception_in, mem_ack, mem_error, mul_div_done,
        output interrupt_pending, global_int_enable,
        input  fetch_enable, decode_enable, exe_enable, mem_enable, wb_enable,
        input  trap_enter, trap_cause, retire, halted
    );
endinterface

// File: rtl/reindeer_pipeline_sequencer.sv
// Multi-cycle instruction sequencer for the Reindeer core. Walks each
// instruction through fetch, decode, execute, memory / mul-div wait and
// write-back with one-cycle stage strobes, and sequences traps, WFI sleep and
// debugger halt. All outputs are registered Moore outputs set on state entry.
//
// Ports:
//   clk      - core clock
//   reset_n  - synchronous active-low reset
//   bus      - reindeer_pipeline_sequencer_if.slave (requests, flags, strobes)
//
// Parameter:
//   MEM_TIMEOUT - cycles allowed in MEM without ack/error before a
//                 timeout trap (1..65535)
//
// state  | meaning
// IDLE   | halted, waiting for start
// FETCH  | fetch strobe on entry, wait for fetch_done from 2nd cycle
// DECODE | decode strobe, single cycle
// EXEC   | execute strobe, dispatch on decoder flags
// MEM    | load/store in flight, timeout counter running
// MULDIV | waiting for mul/div result
// WFI    | sleeping until an interrupt is pending
// WB     | write-back strobe + retire, interrupt/halt decision point
// TRAP   | trap_enter pulse with cause, single cycle
module reindeer_pipeline_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    reindeer_pipeline_sequencer_if.slave  bus
);

    localparam logic [15:0] TMO_LIMIT   = 16'(MEM_TIMEOUT);
    localparam logic [3:0]  CAUSE_ACCESS = 4'd1;
    localparam logic [3:0]  CAUSE_TMO    = 4'd2;
    localparam logic [3:0]  CAUSE_EXEC   = 4'd3;
    localparam logic [3:0]  CAUSE_IRQ    = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_MULDIV,
        S_WB,
        S_WFI,
        S_TRAP
    } state_t;

    state_t      r_state;
    logic        r_fetch_en;
    logic        r_decode_en;
    logic        r_exe_en;
    logic        r_mem_en;
    logic        r_wb_en;
    logic        r_trap_enter;
    logic [3:0]  r_trap_cause;
    logic        r_retire;
    logic        r_halted;
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_fetch_en   <= 1'b0;
            r_decode_en  <= 1'b0;
            r_exe_en     <= 1'b0;
            r_mem_en     <= 1'b0;
            r_wb_en      <= 1'b0;
            r_trap_enter <= 1'b0;
            r_trap_cause <= 4'd0;
            r_retire     <= 1'b0;
            r_halted     <= 1'b1;
            r_tmo_cnt    <= 16'd0;
        end else begin
            // strobes are single-cycle: cleared unless re-armed on a state entry
            r_fetch_en   <= 1'b0;
            r_decode_en  <= 1'b0;
            r_exe_en     <= 1'b0;
            r_mem_en     <= 1'b0;
            r_wb_en      <= 1'b0;
            r_trap_enter <= 1'b0;
            r_retire     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_FETCH;
                        r_fetch_en <= 1'b1;
                        r_halted   <= 1'b0;
                    end
                end

                S_FETCH: begin
                    // fetch_enable is high only in the entry cycle, so it also
                    // marks "don't sample fetch_done yet"
                    if (!r_fetch_en && bus.fetch_done) begin
                        r_state     <= S_DECODE;
                        r_decode_en <= 1'b1;
                    end
                end

                S_DECODE: begin
                    r_state  <= S_EXEC;
                    r_exe_en <= 1'b1;
                end

                S_EXEC: begin
                    if (bus.exception_in) begin
                        r_state      <= S_TRAP;
                        r_trap_enter <= 1'b1;
                        r_trap_cause <= CAUSE_EXEC;
                    end else if (bus.ctl_LOAD || bus.ctl_STORE) begin
                        r_state   <= S_MEM;
                        r_mem_en  <= 1'b1;
                        r_tmo_cnt <= 16'd0;
                    end else if (bus.ctl_MUL_DIV_FUNCT3) begin
                        r_state <= S_MULDIV;
                    end else if (bus.ctl_WFI) begin
                        r_state <= S_WFI;
                    end else if (bus.ctl_MRET) begin
                        // mret retires like an ALU op; the PC redirect happens
                        // in the execute stage itself
                        r_state  <= S_WB;
                        r_wb_en  <= 1'b1;
                        r_retire <= 1'b1;
                    end else begin
                        r_state  <= S_WB;
                        r_wb_en  <= 1'b1;
                        r_retire <= 1'b1;
                    end
                end

                S_MEM: begin
                    if (bus.mem_error) begin
                        r_state      <= S_TRAP;
                        r_trap_enter <= 1'b1;
                        r_trap_cause <= CAUSE_ACCESS;
                    end else if (bus.mem_ack) begin
                        r_state  <= S_WB;
                        r_wb_en  <= 1'b1;
                        r_retire <= 1'b1;
                    end else if (r_tmo_cnt == TMO_LIMIT) begin
                        r_state      <= S_TRAP;
                        r_trap_enter <= 1'b1;
                        r_trap_cause <= CAUSE_TMO;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end

                S_MULDIV: begin
                    if (bus.mul_div_done) begin
                        r_state  <= S_WB;
                        r_wb_en  <= 1'b1;
                        r_retire <= 1'b1;
                    end
                end

                S_WFI: begin
                    // wake on any pending source even with MIE clear; the
                    // trap decision is made later in WB
                    if (bus.interrupt_pending) begin
                        r_state  <= S_WB;
                        r_wb_en  <= 1'b1;
                        r_retire <= 1'b1;
                    end
                end

                S_WB: begin
                    if (bus.halt_req) begin
                        r_state  <= S_IDLE;
                        r_halted <= 1'b1;
                    end else if (bus.interrupt_pending && bus.global_int_enable) begin
                        r_state      <= S_TRAP;
                        r_trap_enter <= 1'b1;
                        r_trap_cause <= CAUSE_IRQ;
                    end else begin
                        r_state    <= S_FETCH;
                        r_fetch_en <= 1'b1;
                    end
                end

                S_TRAP: begin
                    if (bus.halt_req) begin
                        r_state  <= S_IDLE;
                        r_halted <= 1'b1;
                    end else begin
                        r_state    <= S_FETCH;
                        r_fetch_en <= 1'b1;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    assign bus.fetch_enable  = r_fetch_en;
    assign bus.decode_enable = r_decode_en;
    assign bus.exe_enable    = r_exe_en;
    assign bus.mem_enable    = r_mem_en;
    assign bus.wb_enable     = r_wb_en;
    assign bus.trap_enter    = r_trap_enter;
    assign bus.trap_cause    = r_trap_cause;
    assign bus.retire        = r_retire;
    assign bus.halted        = r_halted;

endmodule

// File: tb/tb_reindeer_pipeline_sequencer.sv
// Self-checking bench for reindeer_pipeline_sequencer. Each instruction is
// described by its kind and event timing (fetch delay, ack/error/done offsets,
// interrupt arrival, halt); the expected strobe timeline is computed from the
// sequencing rules and compared against the DUT on every cycle.
module tb_reindeer_pipeline_sequencer;

    localparam int TMO  = 4;
    localparam int NONE = 1000;

    // instruction kinds
    localparam int K_ALU = 0, K_MRET = 1, K_EXC = 2, K_LOAD = 3,
                   K_STORE = 4, K_MULDIV = 5, K_WFI = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    reindeer_pipeline_sequencer_if bus ();

    reindeer_pipeline_sequencer #(.MEM_TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int kind;
        int f;       // fetch_done rises this many cycles after fetch_enable
        int k;       // mem_ack offset from MEM entry (NONE = never)
        int e;       // mem_error offset from MEM entry (NONE = never)
        int d;       // mul_div_done offset from MULDIV entry
        int irq_at;  // interrupt_pending rises at this instruction-relative cycle
        bit gie;
        bit halt;
        bit xf;      // also raise lower-priority decoder flags
    } ins_t;

    typedef struct {
        string name;
        ins_t  ins;
        int    exp_wb;
        int    exp_trap;
        int    exp_cause;
        int    exp_ret;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_cause;
    vec_t       vt[15];

    function automatic vec_t mkv(input string name, input int kind, input int f,
                                 input int k, input int e, input int d, input int irq_at,
                                 input bit gie, input bit halt, input int ewb,
                                 input int etrap, input int ecause, input int eret);
        vec_t v;
        v.name = name;
        v.ins.kind = kind; v.ins.f = f; v.ins.k = k; v.ins.e = e; v.ins.d = d;
        v.ins.irq_at = irq_at; v.ins.gie = gie; v.ins.halt = halt; v.ins.xf = 1'b0;
        v.exp_wb = ewb; v.exp_trap = etrap; v.exp_cause = ecause; v.exp_ret = eret;
        return v;
    endfunction

    // {trap_cause, halted, retire, trap_enter, wb, mem, exe, decode, fetch}
    function automatic logic [11:0] dut_vec();
        return {bus.trap_cause, bus.halted, bus.retire, bus.trap_enter, bus.wb_enable,
                bus.mem_enable, bus.exe_enable, bus.decode_enable, bus.fetch_enable};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_quiet();
        bus.start = 1'b0; bus.halt_req = 1'b0; bus.fetch_done = 1'b0;
        bus.ctl_LOAD = 1'b0; bus.ctl_STORE = 1'b0; bus.ctl_MUL_DIV_FUNCT3 = 1'b0;
        bus.ctl_WFI = 1'b0; bus.ctl_MRET = 1'b0; bus.exception_in = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_error = 1'b0; bus.mul_div_done = 1'b0;
        bus.interrupt_pending = 1'b0; bus.global_int_enable = 1'b0;
    endtask

    // Called while the DUT sits in IDLE; holds for n_idle cycles, then pulses
    // start. Returns at the first FETCH cycle.
    task automatic idle_and_start(input int n_idle);
        for (int i = 0; i <= n_idle; i++) begin
            chk("idle", int'(dut_vec()), int'({exp_cause, 8'h80}));
            bus.start = (i == n_idle);
            bus.halt_req = 1'($urandom_range(0, 1));
            step();
        end
        bus.start = 1'b0;
        bus.halt_req = 1'b0;
    endtask

    // Called at the first FETCH cycle of an instruction (relative cycle 0).
    task automatic run_instr(input ins_t ins, output int o_wb, output int o_trap,
                             output int o_cause, output int o_ret);
        int d_r, e_r, x_r, b_r, t_r, end_r, ncause;
        bit is_mem;
        logic [11:0] ev;

        d_r = ((ins.f < 1) ? 1 : ins.f) + 1;
        e_r = d_r + 1;
        x_r = e_r + 1;
        b_r = NONE;
        t_r = NONE;
        ncause = 0;
        is_mem = (ins.kind == K_LOAD) || (ins.kind == K_STORE);
        case (ins.kind)
            K_ALU, K_MRET: b_r = x_r;
            K_EXC: begin t_r = x_r; ncause = 3; end
            K_LOAD, K_STORE: begin
                if (ins.e <= ins.k && ins.e <= TMO) begin
                    t_r = x_r + ins.e + 1; ncause = 1;
                end else if (ins.k <= TMO) begin
                    b_r = x_r + ins.k + 1;
                end else begin
                    t_r = x_r + TMO + 1; ncause = 2;
                end
            end
            K_MULDIV: b_r = x_r + ins.d + 1;
            default: b_r = ((x_r > ins.irq_at) ? x_r : ins.irq_at) + 1;
        endcase
        if (b_r != NONE) begin
            end_r = b_r;
            if (!ins.halt && ins.gie && ins.irq_at <= b_r) begin
                t_r = b_r + 1; ncause = 8; end_r = t_r;
            end
        end else begin
            end_r = t_r;
        end

        bus.exception_in       = (ins.kind == K_EXC);
        bus.ctl_LOAD           = (ins.kind == K_LOAD) || (ins.xf && ins.kind == K_EXC);
        bus.ctl_STORE          = (ins.kind == K_STORE);
        bus.ctl_MUL_DIV_FUNCT3 = (ins.kind == K_MULDIV) || (ins.xf && ins.kind >= K_EXC && ins.kind <= K_STORE);
        bus.ctl_WFI            = (ins.kind == K_WFI) || (ins.xf && ins.kind >= K_EXC && ins.kind <= K_MULDIV);
        bus.ctl_MRET           = (ins.kind == K_MRET) || (ins.xf && ins.kind >= K_EXC);
        bus.global_int_enable  = ins.gie;
        bus.halt_req           = ins.halt;

        o_wb = NONE; o_trap = NONE; o_cause = 0; o_ret = 0;
        for (int r = 0; r <= end_r; r++) begin
            if (r == t_r) exp_cause = ncause[3:0];
            ev = {exp_cause, 1'b0, r == b_r, r == t_r, r == b_r,
                  is_mem && r == x_r, r == e_r, r == d_r, r == 0};
            chk($sformatf("cycle kind%0d rel%0d", ins.kind, r), int'(dut_vec()), int'(ev));
            if (bus.wb_enable && o_wb == NONE) o_wb = r;
            if (bus.trap_enter && o_trap == NONE) begin
                o_trap = r;
                o_cause = int'(bus.trap_cause);
            end
            if (bus.retire) o_ret++;

            bus.start             = 1'($urandom_range(0, 1));
            bus.fetch_done        = (r >= ins.f);
            bus.mem_ack           = (r >= x_r + ins.k);
            bus.mem_error         = (r >= x_r + ins.e);
            bus.mul_div_done      = (r >= x_r + ins.d);
            bus.interrupt_pending = (r >= ins.irq_at);
            step();
        end
        drive_quiet();
        if (ins.halt) idle_and_start($urandom_range(0, 2));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   o_wb, o_trap, o_cause, o_ret;
        ins_t ri;

        //            name        kind      f  k     e     d  irq   gie halt wb    trap  cause ret
        vt[0]  = mkv("alu",       K_ALU,    0, NONE, NONE, 0, NONE, 0, 0,   4,    NONE, 0, 1);
        vt[1]  = mkv("load_k3",   K_LOAD,   0, 3,    NONE, 0, NONE, 0, 0,   8,    NONE, 0, 1);
        vt[2]  = mkv("store_tmo", K_STORE,  0, NONE, NONE, 0, NONE, 0, 0,   NONE, 9,    2, 0);
        vt[3]  = mkv("err_ack",   K_LOAD,   0, 2,    2,    0, NONE, 0, 0,   NONE, 7,    1, 0);
        vt[4]  = mkv("irq_gie1",  K_ALU,    0, NONE, NONE, 0, 0,    1, 0,   4,    5,    8, 1);
        vt[5]  = mkv("irq_gie0",  K_ALU,    0, NONE, NONE, 0, 0,    0, 0,   4,    NONE, 0, 1);
        vt[6]  = mkv("wfi_10",    K_WFI,    0, NONE, NONE, 0, 14,   0, 0,   15,   NONE, 0, 1);
        vt[7]  = mkv("muldiv_hlt",K_MULDIV, 0, NONE, NONE, 3, NONE, 0, 1,   8,    NONE, 0, 1);
        vt[8]  = mkv("exc",       K_EXC,    0, NONE, NONE, 0, NONE, 0, 0,   NONE, 4,    3, 0);
        vt[9]  = mkv("slow_fetch",K_ALU,    3, NONE, NONE, 0, NONE, 0, 0,   6,    NONE, 0, 1);
        vt[10] = mkv("mret",      K_MRET,   0, NONE, NONE, 0, NONE, 0, 0,   4,    NONE, 0, 1);
        vt[11] = mkv("exc_halt",  K_EXC,    0, NONE, NONE, 0, NONE, 0, 1,   NONE, 4,    3, 0);
        vt[12] = mkv("ack_at_tmo",K_LOAD,   0, 4,    NONE, 0, NONE, 0, 0,   9,    NONE, 0, 1);
        vt[13] = mkv("err_at_tmo",K_LOAD,   0, NONE, 4,    0, NONE, 0, 0,   NONE, 9,    1, 0);
        vt[14] = mkv("ack_late",  K_LOAD,   0, 5,    NONE, 0, NONE, 0, 0,   NONE, 9,    2, 0);

        drive_quiet();
        reset_n = 1'b0;
        exp_cause = 4'd0;
        repeat (3) step();
        chk("reset_state", int'(dut_vec()), int'(12'h080));
        reset_n = 1'b1;
        step();
        idle_and_start(2);

        for (int i = 0; i < 15; i++) begin
            run_instr(vt[i].ins, o_wb, o_trap, o_cause, o_ret);
            chk({vt[i].name, "_wb"},     o_wb,   vt[i].exp_wb);
            chk({vt[i].name, "_trap"},   o_trap, vt[i].exp_trap);
            chk({vt[i].name, "_retire"}, o_ret,  vt[i].exp_ret);
            if (vt[i].exp_trap != NONE)
                chk({vt[i].name, "_cause"}, o_cause, vt[i].exp_cause);
        end

        // reset while a load is waiting in MEM (trap_cause currently 2)
        bus.fetch_done = 1'b1;
        bus.ctl_LOAD = 1'b1;
        repeat (4) step();
        chk("mid_mem_enter", int'(bus.mem_enable), 1);
        step();
        reset_n = 1'b0;
        step();
        exp_cause = 4'd0;
        chk("reset_mid_mem", int'(dut_vec()), int'(12'h080));
        reset_n = 1'b1;
        drive_quiet();
        step();
        idle_and_start(1);

        for (int n = 0; n < 200; n++) begin
            ri.kind   = int'($urandom_range(0, 6));
            ri.f      = int'($urandom_range(0, 3));
            ri.k      = ($urandom_range(0, 3) == 0) ? NONE : int'($urandom_range(0, 6));
            ri.e      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : NONE;
            ri.d      = int'($urandom_range(0, 5));
            ri.irq_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 14)) : NONE;
            if (ri.kind == K_WFI && ri.irq_at == NONE) ri.irq_at = int'($urandom_range(0, 14));
            ri.gie    = 1'($urandom_range(0, 1));
            ri.halt   = ($urandom_range(0, 7) == 0);
            ri.xf     = 1'($urandom_range(0, 1));
            run_instr(ri, o_wb, o_trap, o_cause, o_ret);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reindeer_pipeline_sequencer.md
# reindeer_pipeline_sequencer

Multi-cycle sequencer for the Reindeer core. It steps each instruction through fetch, decode, execute, memory/mul-div wait and write-back by issuing one-cycle stage enables, and it sequences traps, WFI sleep and debugger halt. It sits between the on-chip-debug boot/halt logic and the fetch, decode, execute, memory and register-file stages. It consumes the decoder's registered control flags (`ctl_*`) during the execute step.

## Interface
- `MEM_TIMEOUT`, default 255: cycles allowed between `mem_enable` and `mem_ack` before a timeout trap; legal range 1..65535.
- `clk` in 1: core clock.
- `reset_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start` in 1: pulse; leaves IDLE and begins fetching.
- `halt_req` in 1: level; debugger halt request, honoured only at an instruction boundary.
- `fetch_done` in 1: instruction word valid at the fetch stage.
- `ctl_LOAD`, `ctl_STORE`, `ctl_MUL_DIV_FUNCT3`, `ctl_WFI`, `ctl_MRET` in 1 each: decoder control flags, valid in EXEC.
- `exception_in` in 1: execute-stage exception (illegal instruction, ecall, misaligned target), valid in EXEC.
- `mem_ack` in 1: load/store complete.
- `mem_error` in 1: load/store bus error.
- `mul_div_done` in 1: mul/div result ready.
- `interrupt_pending` in 1: level; any enabled interrupt source is pending.
- `global_int_enable` in 1: level; mstatus.MIE.
- `fetch_enable`, `decode_enable`, `exe_enable`, `mem_enable`, `wb_enable` out 1 each: one-cycle stage strobes.
- `trap_enter` out 1: one-cycle pulse on entry to the trap handler.
- `trap_cause` out 4: cause code, valid while `trap_enter` = 1 and held until the next trap.
- `retire` out 1: one-cycle pulse per completed instruction (minstret increment).
- `halted` out 1: level; high in IDLE.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, MULDIV, WB, WFI, TRAP. All outputs are registered Moore outputs. Every strobe is asserted only in the first cycle of its state.
- IDLE:
  - `halted` = 1.
  - `start` = 1 → FETCH.
- FETCH:
  - `fetch_enable` is asserted on the entry cycle.
  - `fetch_done` is sampled from the second cycle onward; when set → DECODE.
- DECODE: `decode_enable` for 1 cycle, then → EXEC unconditionally.
- EXEC: `exe_enable` for 1 cycle. Next state is chosen by the first matching rule, in this order:
  - `exception_in` → TRAP, cause 3.
  - `ctl_LOAD` | `ctl_STORE` → MEM.
  - `ctl_MUL_DIV_FUNCT3` → MULDIV.
  - `ctl_WFI` → WFI.
  - otherwise → WB. `ctl_MRET` also goes to WB; the PC redirect is performed by the execute stage.
- MEM:
  - `mem_enable` is asserted on the entry cycle, and the timeout counter is cleared to 0.
  - Each cycle, in priority order:
    - `mem_error` → TRAP, cause 1.
    - `mem_ack` → WB.
    - counter == `MEM_TIMEOUT` → TRAP, cause 2.
    - otherwise the counter increments.
  - If `mem_error` and `mem_ack` arrive together, `mem_error` wins.
- MULDIV: wait for `mul_div_done` → WB. There is no timeout.
- WFI: `interrupt_pending` = 1 → WB, regardless of `global_int_enable`. WFI retires normally.
- WB:
  - `wb_enable` = 1 and `retire` = 1 for 1 cycle.
  - Next state, in priority order:
    - `halt_req` → IDLE.
    - `interrupt_pending` & `global_int_enable` → TRAP, cause 8.
    - otherwise → FETCH.
- TRAP:
  - `trap_enter` = 1 for 1 cycle, with `trap_cause` already valid.
  - `retire` = 0 when the trap came from EXEC or MEM.
  - `halt_req` → IDLE; otherwise → FETCH.
- Cause codes: 1 = access fault, 2 = memory timeout, 3 = execute exception, 8 = interrupt. All other codes are reserved.
- Interrupts are taken only in WB. An instruction in flight always completes or traps first.
- `halt_req` is ignored outside WB and TRAP. `start` is ignored outside IDLE.

## Timing
- Reset (`reset_n` = 0 at a rising edge):
  - state = IDLE.
  - all strobes, `trap_enter` and `retire` = 0; `trap_cause` = 0; `halted` = 1; timeout counter = 0.
- Reset takes effect from any state, including MEM or MULDIV in progress. No strobe is emitted on the cycle after reset.
- ALU instruction, fetch in the minimum time (`start` sampled at cycle 0):
  - FETCH cycles 1–2 (`fetch_enable` at 1, `fetch_done` sampled at 2).
  - DECODE at 3.
  - EXEC at 4.
  - WB at 5.
  - next FETCH at 6.
  - Total: 5 cycles per instruction.
- Load/store adds 1 + k cycles, where `mem_ack` arrives k ≥ 1 cycles after `mem_enable` (k is counted from MEM entry).
- The timeout trap fires when MEM is entered at cycle t with no `mem_ack`/`mem_error`: TRAP at cycle t + `MEM_TIMEOUT` + 1.
- Stage strobes are mutually exclusive. At most one of `wb_enable`/`trap_enter` is high in any cycle.

## Test plan
- Reset, then `start` at cycle 0, ALU op, `fetch_done` held at 1 → `fetch_enable`@1, `decode_enable`@3, `exe_enable`@4, `wb_enable` and `retire`@5, `fetch_enable`@6.
- Load with `mem_ack` 3 cycles after `mem_enable` → `wb_enable` on the cycle after the ack; `retire` pulses exactly once.
- `MEM_TIMEOUT` = 4, store with no ack → `trap_enter` with `trap_cause` = 2 exactly 5 cycles after `mem_enable`; `retire` = 0.
- `mem_error` and `mem_ack` asserted in the same cycle → TRAP with cause 1; no `wb_enable`.
- `interrupt_pending` = 1 during an ALU op: with `global_int_enable` = 1 → WB then `trap_enter` with cause 8; with `global_int_enable` = 0 → WB then FETCH.
- WFI, with `interrupt_pending` raised 10 cycles later → the sequencer stays in WFI with no strobes, then WB (`retire`). Separately: `halt_req` during MULDIV → no effect until WB, then IDLE with `halted` = 1. `reset_n` = 0 mid-MEM → IDLE next cycle with all outputs at reset values.
